reg_dump_unit: RTL and testbench

Debug readout engine for the RV32I register file. On a start pulse it walks x0..x(NUM_REGS-1) through one asynchronous register-file read port and streams the contents as bytes over a valid/ready interface, normally into the UART transmitter. It sits between the register file's spare read port and the debug TX path, and lets the host snapshot architectural state while the core is halted.

---
 rtl/reg_dump_pkg.sv | 18 +
 rtl/reg_dump_if.sv | 9 +
 rtl/word_serializer.sv | 46 ++++
 rtl/reg_dump_unit.sv | 111 +++++++++++
 tb/tb_reg_dump_unit.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_dump_pkg.sv
// Shared types and constants for the register-file dump engine.
package reg_dump_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    LOAD,
    SEND,
    DONE
  } state_t;

  localparam logic [7:0] DEFAULT_HEADER_BYTE = 8'hA5;

  function automatic int bytes_per_reg(input int reg_width);
    return reg_width / 8;
  endfunction

endpackage

// File: rtl/reg_dump_if.sv
// Byte stream valid/ready bus from the dump engine towards the debug TX path.
interface reg_dump_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/word_serializer.sv
// Holds one register word and presents its bytes LSB first; last_o flags the final byte.
module word_serializer
  import reg_dump_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] word_i,
  input  logic             advance_i,
  output logic [7:0]       byte_o,
  output logic             last_o
);

  localparam int BPR   = bytes_per_reg(WIDTH);
  localparam int IDX_W = (BPR > 1) ? $clog2(BPR) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BPR - 1);

  logic [WIDTH-1:0] r_shift;
  logic [IDX_W-1:0] r_byte_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift    <= '0;
      r_byte_idx <= '0;
    end else begin
      // Index returns to zero after the last byte so the next word starts clean.
      if (clr_i) begin
        r_byte_idx <= '0;
      end else if (advance_i) begin
        r_byte_idx <= last_o ? '0 : r_byte_idx + IDX_W'(1);
      end
      if (load_i) begin
        r_shift <= word_i;
      end else if (advance_i) begin
        r_shift <= r_shift >> 8;
      end
    end
  end

  assign byte_o = r_shift[7:0];
  assign last_o = (r_byte_idx == LAST_IDX);

endmodule

// File: rtl/reg_dump_unit.sv
// Walks the register file through one read port and streams a header byte plus
// every register, little-endian, over a valid/ready byte bus.
module reg_dump_unit
  import reg_dump_pkg::*;
#(
  parameter int         REG_WIDTH   = 32,
  parameter int         NUM_REGS    = 32,
  parameter logic [7:0] HEADER_BYTE = DEFAULT_HEADER_BYTE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [4:0]           rf_addr_o,
  input  logic [REG_WIDTH-1:0] rf_data_i,
  reg_dump_if.master           tx
);

  localparam logic [4:0] LAST_REG = 5'(NUM_REGS - 1);

  state_t     r_state;
  state_t     w_next_state;
  logic [4:0] r_reg_idx;
  logic       w_start;
  logic       w_load;
  logic       w_advance;
  logic       w_last_byte;
  logic [7:0] w_byte;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_load       = 1'b0;
    w_advance    = 1'b0;
    busy_o       = 1'b1;
    done_o       = 1'b0;
    tx.tx_valid  = 1'b0;
    tx.tx_data   = '0;
    case (r_state)
      IDLE: begin
        busy_o = 1'b0;
        if (start_i) begin
          w_start      = 1'b1;
          w_next_state = HEADER;
        end
      end
      HEADER: begin
        tx.tx_valid = 1'b1;
        tx.tx_data  = HEADER_BYTE;
        if (tx.tx_ready) begin
          w_next_state = LOAD;
        end
      end
      LOAD: begin
        w_load       = 1'b1;
        w_next_state = SEND;
      end
      SEND: begin
        tx.tx_valid = 1'b1;
        tx.tx_data  = w_byte;
        if (tx.tx_ready) begin
          w_advance = 1'b1;
          if (w_last_byte) begin
            w_next_state = (r_reg_idx == LAST_REG) ? DONE : LOAD;
          end
        end
      end
      DONE: begin
        done_o       = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // reg_idx doubles as the registered read address, so it stays put through SEND.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reg_idx <= '0;
    end else if (w_start) begin
      r_reg_idx <= '0;
    end else if (w_advance && w_last_byte && (r_reg_idx != LAST_REG)) begin
      r_reg_idx <= r_reg_idx + 5'd1;
    end
  end

  assign rf_addr_o = r_reg_idx;

  word_serializer #(
    .WIDTH (REG_WIDTH)
  ) u_ser (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (w_start),
    .load_i    (w_load),
    .word_i    (rf_data_i),
    .advance_i (w_advance),
    .byte_o    (w_byte),
    .last_o    (w_last_byte)
  );

endmodule

// File: tb/tb_reg_dump_unit.sv
// Scoreboard bench: expected bytes are queued at start, popped as the DUT transfers them.
module tb_reg_dump_unit;
  import reg_dump_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Full-size instance with a 32x32 register file model
  reg_dump_if  tx_a();
  logic        start_a = 1'b0;
  logic        busy_a, done_a;
  logic [4:0]  addr_a;
  logic [31:0] rf [32];
  logic [31:0] rdata_a;
  assign rdata_a = rf[addr_a];

  reg_dump_unit #(.REG_WIDTH(32), .NUM_REGS(32), .HEADER_BYTE(8'hA5)) u_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (start_a),
    .busy_o    (busy_a),
    .done_o    (done_a),
    .rf_addr_o (addr_a),
    .rf_data_i (rdata_a),
    .tx        (tx_a)
  );

  // Minimal instance: one 8-bit register
  reg_dump_if  tx_b();
  logic        start_b = 1'b0;
  logic        busy_b, done_b;
  logic [4:0]  addr_b;
  logic [7:0]  rdata_b;
  assign rdata_b = (addr_b == 5'd0) ? 8'h00 : 8'h77;

  reg_dump_unit #(.REG_WIDTH(8), .NUM_REGS(1), .HEADER_BYTE(8'hA5)) u_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (start_b),
    .busy_o    (busy_b),
    .done_o    (done_b),
    .rf_addr_o (addr_b),
    .rf_data_i (rdata_b),
    .tx        (tx_b)
  );

  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  int got_a = 0, done_cnt_a = 0, done_cyc_a = 0;
  int got_b = 0, done_cnt_b = 0, done_cyc_b = 0;
  logic rnd_mode = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    tx_b.tx_ready = 1'b1;
    tx_a.tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tx_a.tx_ready = rnd_mode ? ($urandom_range(0, 99) < 30) : 1'b1;
    end
  end

  // Inputs move only at posedge+1, so valid&&ready at negedge is the transfer of the next edge.
  initial begin
    logic       hold_pend;
    logic [7:0] hold_data;
    logic [7:0] e;
    hold_pend = 1'b0;
    hold_data = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_pend = 1'b0;
      end else begin
        if (hold_pend) begin
          check_val("hold_valid", 32'(tx_a.tx_valid), 32'd1);
          check_val("hold_data", 32'(tx_a.tx_data), 32'(hold_data));
        end
        hold_pend = tx_a.tx_valid && !tx_a.tx_ready;
        hold_data = tx_a.tx_data;
        if (tx_a.tx_valid && tx_a.tx_ready) begin
          if (q_a.size() == 0) begin
            check_val("unexpected_byte_a", 32'(q_a.size()), 32'd1);
          end else begin
            e = q_a.pop_front();
            check_val($sformatf("byte_a[%0d]", got_a), 32'(tx_a.tx_data), 32'(e));
          end
          got_a++;
        end
        if (done_a) begin
          done_cnt_a++;
          done_cyc_a = cyc;
        end
        if (tx_b.tx_valid && tx_b.tx_ready) begin
          if (q_b.size() == 0) begin
            check_val("unexpected_byte_b", 32'(q_b.size()), 32'd1);
          end else begin
            e = q_b.pop_front();
            check_val($sformatf("byte_b[%0d]", got_b), 32'(tx_b.tx_data), 32'(e));
          end
          got_b++;
        end
        if (done_b) begin
          done_cnt_b++;
          done_cyc_b = cyc;
        end
      end
    end
  end

  task automatic push_a();
    q_a.push_back(8'hA5);
    for (int r = 0; r < 32; r++)
      for (int b = 0; b < 4; b++)
        q_a.push_back(rf[r][8*b +: 8]);
  endtask

  // Returns the cycle number of the edge that sampled start.
  task automatic start_dump_a(output int e0);
    @(posedge clk);
    #1;
    start_a = 1'b1;
    push_a();
    @(posedge clk);
    #1;
    e0 = cyc;
    start_a = 1'b0;
  endtask

  task automatic wait_done_a(input string tag, input int budget);
    int c0;
    c0 = done_cnt_a;
    for (int i = 0; i < budget && done_cnt_a == c0; i++) @(posedge clk);
    repeat (10) @(posedge clk);
    #2;
    check_val({tag, "_done_once"}, 32'(done_cnt_a - c0), 32'd1);
    check_val({tag, "_idle"}, 32'(busy_a), 32'd0);
    check_val({tag, "_sb_left"}, 32'(q_a.size()), 32'd0);
  endtask

  task automatic check_zero_a(input string tag);
    check_val({tag, "_busy"}, 32'(busy_a), 32'd0);
    check_val({tag, "_done"}, 32'(done_a), 32'd0);
    check_val({tag, "_valid"}, 32'(tx_a.tx_valid), 32'd0);
    check_val({tag, "_data"}, 32'(tx_a.tx_data), 32'd0);
    check_val({tag, "_addr"}, 32'(addr_a), 32'd0);
  endtask

  initial begin
    int e0, g0, i;
    for (int n = 0; n < 32; n++) rf[n] = 32'h0101_0100 * n + n;

    repeat (3) @(posedge clk);
    #2;
    check_zero_a("rst");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check_zero_a("post_rst");

    // Steady ready: exact latency of done
    start_dump_a(e0);
    wait_done_a("full", 400);
    check_val("done_latency", 32'(done_cyc_a - e0), 32'd161);
    check_val("full_count", 32'(got_a), 32'd129);

    // Random backpressure
    rnd_mode = 1'b1;
    g0 = got_a;
    start_dump_a(e0);
    wait_done_a("rnd", 3000);
    check_val("rnd_count", 32'(got_a - g0), 32'd129);
    rnd_mode = 1'b0;
    repeat (2) @(posedge clk);

    // Start pulsed mid-dump must be ignored
    g0 = got_a;
    start_dump_a(e0);
    for (i = 0; i < 400 && (got_a - g0) < 50; i++) @(posedge clk);
    #1;
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    wait_done_a("restart", 400);
    check_val("restart_count", 32'(got_a - g0), 32'd129);

    // x5 written after its LOAD: dump keeps old value, next dump shows new
    start_dump_a(e0);
    for (i = 0; i < 400 && !(addr_a == 5'd5 && tx_a.tx_valid); i++) begin
      @(posedge clk);
      #2;
    end
    rf[5] = 32'hDEAD_BEEF;
    wait_done_a("snap_old", 400);
    start_dump_a(e0);
    wait_done_a("snap_new", 400);

    // Reset during SEND of x10
    start_dump_a(e0);
    for (i = 0; i < 400 && !(addr_a == 5'd10 && tx_a.tx_valid); i++) begin
      @(posedge clk);
      #2;
    end
    rst_n = 1'b0;
    #1;
    check_zero_a("mid_rst");
    q_a.delete();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    g0 = got_a;
    start_dump_a(e0);
    wait_done_a("after_rst", 400);
    check_val("after_rst_count", 32'(got_a - g0), 32'd129);

    // One 8-bit register
    @(posedge clk);
    #1;
    start_b = 1'b1;
    q_b.push_back(8'hA5);
    q_b.push_back(8'h00);
    @(posedge clk);
    #1;
    e0 = cyc;
    start_b = 1'b0;
    for (i = 0; i < 50 && done_cnt_b == 0; i++) @(posedge clk);
    repeat (5) @(posedge clk);
    #2;
    check_val("small_done_once", 32'(done_cnt_b), 32'd1);
    check_val("small_done_lat", 32'(done_cyc_b - e0), 32'd3);
    check_val("small_count", 32'(got_b), 32'd2);
    check_val("small_sb_left", 32'(q_b.size()), 32'd0);
    check_val("small_idle", 32'(busy_b), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
